// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 serial demux/deserializer.
package demux_pkg;

    localparam int unsigned NUM_CH        = 4;
    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        STALL = 2'd2
    } lane_state_t;

endpackage

// File: rtl/demux_lane.sv
// One channel: MSB-first serial deserializer plus a holding register with
// valid/ack handshake and a stall indication for the final bit of a word.
module demux_lane
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic             ack,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic             ready_c
);

    localparam int unsigned      CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    lane_state_t      state_q, state_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] nxt_word;
    logic             complete;
    logic             valid_d;

    // Register stage: everything observable comes straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            shift_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    // Next-state: a completing bit wins over an ack of the previous word.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        nxt_word = {shift_q, bit_in};
        complete = shift_en && (cnt_q == LAST);
        valid_d  = (state_q != EMPTY);

        if (shift_en) begin
            shift_d = nxt_word[WIDTH-2:0];
            cnt_d   = complete ? '0 : cnt_q + CNT_W'(1);
        end

        if (complete) begin
            word_d  = nxt_word;
            valid_d = 1'b1;
        end else if ((state_q != EMPTY) && ack) begin
            valid_d = 1'b0;
        end

        if (!valid_d) begin
            state_d = EMPTY;
        end else if (cnt_d == LAST) begin
            state_d = STALL;
        end else begin
            state_d = HOLD;
        end
    end

    assign word    = word_q;
    assign valid   = (state_q != EMPTY);
    assign ready_c = !((state_q == STALL) && !ack);

endmodule

// File: rtl/demux_1x4_deser.sv
// 1-to-4 serial demultiplexer: routes accepted bits to the selected lane's
// deserializer; in_ready reflects whether that lane can take the bit now.
module demux_1x4_deser
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    I,
    input  logic                    in_valid,
    input  logic                    Sel0,
    input  logic                    Sel1,
    output logic                    in_ready,
    output logic [4*WIDTH-1:0]      out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ack
);

    ch_idx_t           sel;
    logic [NUM_CH-1:0] lane_ready;
    logic              accept;

    assign sel      = {Sel1, Sel0};
    assign in_ready = lane_ready[sel];
    assign accept   = in_valid && in_ready;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        demux_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .shift_en(accept && (sel == ch_idx_t'(n))),
            .bit_in  (I),
            .ack     (out_ack[n]),
            .word    (out_data[n*WIDTH +: WIDTH]),
            .valid   (out_valid[n]),
            .ready_c (lane_ready[n])
        );
    end

endmodule

// File: doc/demux_1x4_deser.md
DEMUX_1X4_DESER -- requirements
Module: demux_1x4_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bits per output word (minimum 2).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port I, input, 1: serial data bit.
REQ-005 SHALL have port in_valid, input, 1: I is valid this cycle.
REQ-006 SHALL have port Sel0, input, 1: destination channel select, LSB.
REQ-007 SHALL have port Sel1, input, 1: destination channel select, MSB; channel = {Sel1, Sel0}.
REQ-008 SHALL have port in_ready, output, 1: the selected channel can accept I this cycle.
REQ-009 SHALL have port out_data, output, 4*WIDTH: channel n word at bits [n*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid, output, 4: channel n holds a complete word.
REQ-011 SHALL have port out_ack, input, 4: consumer takes channel n word.

Function
REQ-012 SHALL accept a bit only when in_valid && in_ready; the bit goes to channel {Sel1,Sel0} only, and other channels are unchanged.
REQ-013 Each channel SHALL have an independent shift register and bit counter (0..WIDTH-1), MSB-first: shift = {shift[WIDTH-2:0], I}.
REQ-014 On the WIDTH-th accepted bit, the channel SHALL load the full word into its holding register, set out_valid[n] on the next edge, and clear its counter. Latency is 1 cycle from the last accept.
REQ-015 Partial words SHALL be retained per channel when Sel changes, so interleaved streams to different channels do not corrupt each other.
REQ-016 out_valid[n] && out_ack[n] SHALL clear out_valid[n] on the next edge, unless a new word loads that same edge.
REQ-017 out_ack[n] while out_valid[n]=0 SHALL be ignored.
REQ-018 in_ready SHALL be 0 only when:
  - the selected channel's counter = WIDTH-1, and
  - out_valid[sel]=1, and
  - out_ack[sel]=0.
  This is a combinational path from out_ack to in_ready.
REQ-019 Simultaneous ack and completing bit on the same channel SHALL load the new word, keep out_valid[n]=1, and discard the old word (consumed).
REQ-020 out_data slice n SHALL hold its value while out_valid[n]=1, and SHALL keep the last word after ack until overwritten.
REQ-021 Per-channel states SHALL be:
  - EMPTY: counter<WIDTH, no valid word.
  - HOLD: valid word, collecting next word.
  - STALL: valid word, counter=WIDTH-1, not acked.
  Transitions SHALL follow REQ-014/016/018.

Reset
REQ-022 rst SHALL clear all shift registers, counters, out_data (0) and out_valid (4'b0000). The outputs SHALL be 0 from the first cycle after the rst edge.
REQ-023 rst mid-word SHALL discard all partial and held words. in_ready SHALL be 1 after reset.
REQ-024 rst SHALL take priority over in_valid and out_ack in the same cycle.

Structure
REQ-025 A shared package demux_pkg SHALL hold:
  - NUM_CH=4;
  - the default WIDTH;
  - the 2-bit channel-index type;
  - the lane state enum (EMPTY/HOLD/STALL).
REQ-026 SHALL instantiate one sub-module demux_lane (per-channel deserializer plus holding register) four times. Top-level select decode and in_ready muxing SHALL live in demux_1x4_deser.

Verification
REQ-027 Sel=0, bits 1,0,1,1 on consecutive cycles -> out_valid=4'b0001 the cycle after the 4th bit, out_data[3:0]=4'hB, all other slices 0.
REQ-028 Interleave: ch1 bits 1,1; ch2 bits 0,1,0,1; ch1 bits 0,0 -> ch2 word 4'h5 first, then ch1 word 4'hC; no cross-contamination.
REQ-029 ch3 holds unacked 4'hA; send 0,1,0 -> accepted, 4th bit 1 sees in_ready=0; assert out_ack[3] -> bit accepted that cycle, out_valid[3] stays 1, out_data[15:12]=4'h5 next cycle.
REQ-030 Two bits into ch0, then rst pulse -> all outputs 0; then bits 1,1,1,1 -> out_data[3:0]=4'hF, with no leftover bits.
REQ-031 out_ack=4'b1111 with out_valid=0 -> no state change; ack of ch2 in the same cycle as ch0 word completion -> out_valid goes 4'b0100 to 4'b0001.
